// File: rtl/ndp_pkg.sv
// Shared definitions for the NDP result read-out path.
// Holds AHB-Lite response and transfer encodings, the accepted transfer size,
// the status word index and the error-response FSM state type.
package ndp_pkg;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] SIZE_WORD = 3'b010;

    localparam int unsigned STATUS_WORD_IDX = 0;

    // Two-cycle AHB ERROR response sequencing.
    typedef enum logic [1:0] {
        StIdle,
        StErr1,
        StErr2
    } err_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single-bit level crossing into clk_i.
// Ports:
//   clk_i  - destination clock
//   rst_ni - asynchronous active-low reset, clears both stages
//   d_i    - asynchronous input level
//   q_o    - synchronized level, two clk_i edges behind d_i
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ndp_result_reader.sv
// AHB-Lite read-only slave exposing a registered snapshot of the NDP core result.
// A rising edge of the (synchronized) core done level captures out_c into the
// snapshot, sets the valid flag and bumps a 16-bit capture counter.
// Word 0 is status {cap_cnt, 15'b0, valid}; words 1..N hold the snapshot, two
// elements per word with the lower element in the low half.
// Ports:
//   HCLK, HRESETn         - clock, asynchronous active-low reset
//   HSEL..HREADYin        - AHB-Lite address-phase inputs
//   HREADYOUT/HRESP/HRDATA - registered AHB-Lite data-phase outputs
//   done_in               - core completion level (asynchronous)
//   clear_in              - clears the valid flag; a same-cycle capture wins
//   out_c                 - packed core result, element i at [i*WIDTH +: WIDTH]
module ndp_result_reader
    import ndp_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned NUM_ELEMS = 1024,
    parameter int unsigned ADDR_BITS = 13
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    input  logic                       HSEL,
    input  logic [31:0]                HADDR,
    input  logic [1:0]                 HTRANS,
    input  logic                       HWRITE,
    input  logic [2:0]                 HSIZE,
    input  logic                       HREADYin,
    output logic                       HREADYOUT,
    output logic [1:0]                 HRESP,
    output logic [31:0]                HRDATA,
    input  logic                       done_in,
    input  logic                       clear_in,
    input  logic [NUM_ELEMS*WIDTH-1:0] out_c
);

    localparam int unsigned NumWords = NUM_ELEMS * WIDTH / 32;
    localparam int unsigned WordIdxW = ADDR_BITS - 2;
    localparam int unsigned DataIdxW = (NumWords > 1) ? $clog2(NumWords) : 1;

    localparam logic [WordIdxW-1:0] LastWord  = WordIdxW'(NumWords);
    localparam logic [WordIdxW-1:0] StatusIdx = WordIdxW'(STATUS_WORD_IDX);

    err_state_e                   state_q, state_d;
    logic                         hreadyout_q, hreadyout_d;
    logic [1:0]                   hresp_q, hresp_d;
    logic [31:0]                  hrdata_q, hrdata_d;
    logic [NumWords-1:0][31:0]    snap_q, snap_d;
    logic                         valid_q, valid_d;
    logic [15:0]                  cap_cnt_q, cap_cnt_d;
    logic                         done_s_d_q;

    logic                         done_s;
    logic                         capture;
    logic                         trans_active;
    logic                         accept;
    logic                         addr_err;
    logic [WordIdxW-1:0]          word_idx;
    logic [DataIdxW-1:0]          data_idx;
    logic [31:0]                  rd_word;
    logic                         unused_addr;

    sync_2ff u_done_sync (
        .clk_i  (HCLK),
        .rst_ni (HRESETn),
        .d_i    (done_in),
        .q_o    (done_s)
    );

    assign capture     = done_s & ~done_s_d_q;
    assign word_idx    = HADDR[ADDR_BITS-1:2];
    assign data_idx    = DataIdxW'(word_idx - 1'b1);
    assign unused_addr = ^HADDR[31:ADDR_BITS];

    always_comb begin
        trans_active = 1'b0;
        unique case (HTRANS)
            HTRANS_NONSEQ, HTRANS_SEQ: trans_active = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  trans_active = 1'b0;
            default:                   trans_active = 1'b0;
        endcase

        // HREADYin is low during the first error cycle; gating on state as well
        // keeps a misbehaving interconnect from restarting the response early.
        accept   = HSEL & trans_active & HREADYin & (state_q != StErr1);
        addr_err = HWRITE | (HSIZE != SIZE_WORD) | (HADDR[1:0] != 2'b00) |
                   (word_idx > LastWord);

        // Read from the current snapshot so a capture on the same edge is not seen.
        rd_word = (word_idx == StatusIdx) ? {cap_cnt_q, 15'b0, valid_q} : snap_q[data_idx];

        snap_d    = capture ? out_c : snap_q;
        cap_cnt_d = capture ? cap_cnt_q + 16'd1 : cap_cnt_q;
        valid_d   = capture ? 1'b1 : (clear_in ? 1'b0 : valid_q);

        state_d     = state_q;
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_OKAY;
        hrdata_d    = hrdata_q;
        unique case (state_q)
            StErr1: begin
                state_d = StErr2;
                hresp_d = HRESP_ERROR;
            end
            StIdle, StErr2: begin
                state_d = StIdle;
                if (accept && addr_err) begin
                    state_d     = StErr1;
                    hreadyout_d = 1'b0;
                    hresp_d     = HRESP_ERROR;
                end else if (accept) begin
                    hrdata_d = rd_word;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= StIdle;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            hrdata_q    <= '0;
            snap_q      <= '0;
            valid_q     <= 1'b0;
            cap_cnt_q   <= '0;
            done_s_d_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
            snap_q      <= snap_d;
            valid_q     <= valid_d;
            cap_cnt_q   <= cap_cnt_d;
            done_s_d_q  <= done_s;
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = hrdata_q;

endmodule
